// File: rtl/score_engine.sv
// Multi-player combo/score engine with high-score tracking and a sequential
// double-dabble BCD readout. Optional streak bonus: SCORE_ENGINE_STREAK_BONUS_EN.
module score_engine #(
    parameter  int NUM_PLAYERS = 2,
    parameter  int MAX_SCORE   = 9999,
    parameter  int MAX_COMBO   = 99,
    parameter  int BASE_POINTS = 1,
    parameter  int DIGITS      = 4,
    localparam int SW          = $clog2(MAX_SCORE + 1),
    localparam int CW          = $clog2(MAX_COMBO + 1),
    localparam int SELW        = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PLAYERS-1:0]    hit,
    input  logic [NUM_PLAYERS-1:0]    miss,
    input  logic                      clear,
    output logic [NUM_PLAYERS*SW-1:0] score,
    output logic [NUM_PLAYERS*CW-1:0] combo,
    output logic [SW-1:0]             high_score,
    input  logic                      bcd_req,
    input  logic [SELW-1:0]           bcd_sel,
    output logic                      bcd_busy,
    output logic                      bcd_valid,
    output logic [4*DIGITS-1:0]       bcd_out
);

    localparam int SUMW = SW + CW + 4;
    localparam int DDW  = 4 * DIGITS + SW;
    localparam int CNTW = $clog2(SW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SW-1:0]     score_q    [NUM_PLAYERS];
    logic [CW-1:0]     combo_q    [NUM_PLAYERS];
    logic [SW-1:0]     score_next [NUM_PLAYERS];
    logic [CW-1:0]     combo_next [NUM_PLAYERS];
    logic [SW-1:0]     high_q;
    logic [SW-1:0]     high_next;
    logic [SUMW-1:0]   sum;
    state_t            state, state_next;
    logic [DDW-1:0]    dd_q;
    logic [DDW-1:0]    dd_step;
    logic [CNTW-1:0]   cnt_q;
    logic [SW-1:0]     sel_value;
    logic [4*DIGITS-1:0] bcd_q;

    function automatic logic [CW-1:0] sat_combo(input logic [CW-1:0] c);
        if (c >= CW'(MAX_COMBO)) return CW'(MAX_COMBO);
        return c + CW'(1);
    endfunction

    function automatic logic [SW-1:0] sat_score(input logic [SUMW-1:0] s);
        if (s > SUMW'(MAX_SCORE)) return SW'(MAX_SCORE);
        return s[SW-1:0];
    endfunction

`ifdef SCORE_ENGINE_STREAK_BONUS_EN
    // Bonus only on a real increment, so sitting at a capped multiple of 10 pays nothing extra.
    function automatic logic [SUMW-1:0] streak_bonus(input logic [CW-1:0] c_old,
                                                     input logic [CW-1:0] c_new);
        if (c_old != c_new && c_new != '0 && (c_new % CW'(10)) == '0)
            return SUMW'(10 * BASE_POINTS);
        return '0;
    endfunction
`endif

    function automatic logic [DDW-1:0] dabble_step(input logic [DDW-1:0] v);
        logic [DDW-1:0] t;
        t = v;
        for (int d = 0; d < DIGITS; d++)
            if (t[SW+4*d +: 4] >= 4'd5) t[SW+4*d +: 4] = t[SW+4*d +: 4] + 4'd3;
        return {t[DDW-2:0], 1'b0};
    endfunction

    always_comb begin
        high_next = high_q;
        sum       = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_next[i] = score_q[i];
            combo_next[i] = combo_q[i];
            if (clear) begin
                score_next[i] = '0;
                combo_next[i] = '0;
            end else if (miss[i]) begin
                combo_next[i] = '0;
            end else if (hit[i]) begin
                combo_next[i] = sat_combo(combo_q[i]);
`ifdef SCORE_ENGINE_STREAK_BONUS_EN
                sum = SUMW'(score_q[i]) + SUMW'(BASE_POINTS) * SUMW'(combo_next[i])
                    + streak_bonus(combo_q[i], combo_next[i]);
`else
                sum = SUMW'(score_q[i]) + SUMW'(BASE_POINTS) * SUMW'(combo_next[i]);
`endif
                score_next[i] = sat_score(sum);
            end
            if (score_next[i] > high_next) high_next = score_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_q <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
                combo_q[i] <= '0;
            end
        end else begin
            high_q <= high_next;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_next[i];
                combo_q[i] <= combo_next[i];
            end
        end
    end

    always_comb begin
        score = '0;
        combo = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score[i*SW +: SW] = score_q[i];
            combo[i*CW +: CW] = combo_q[i];
        end
    end
    assign high_score = high_q;

    // Out-of-range selects fall back to the high score.
    always_comb begin
        sel_value = high_q;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (bcd_sel == SELW'(i)) sel_value = score_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bcd_req) state_next = SHIFT;
            SHIFT:   if (cnt_q == CNTW'(SW - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_busy  = (state != IDLE);
        bcd_valid = (state == DONE);
    end

    assign dd_step = dabble_step(dd_q);

    // The last shift loads bcd_out directly so it is stable throughout the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dd_q  <= '0;
            cnt_q <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                IDLE: if (bcd_req) begin
                    dd_q  <= {{(4*DIGITS){1'b0}}, sel_value};
                    cnt_q <= '0;
                end
                SHIFT: begin
                    dd_q  <= dd_step;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(SW - 1)) bcd_q <= dd_step[DDW-1:SW];
                end
                default: ;
            endcase
        end
    end
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_score_engine.sv
// Directed self-checking bench for score_engine at default parameters.
module tb_score_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hit, miss;
    logic        clear;
    logic [27:0] score;
    logic [13:0] combo;
    logic [13:0] high_score;
    logic        bcd_req;
    logic [1:0]  bcd_sel;
    logic        bcd_busy, bcd_valid;
    logic [15:0] bcd_out;

    int errors = 0;
    int checks = 0;

`ifdef SCORE_ENGINE_STREAK_BONUS_EN
    localparam int          E120  = 7119;
    localparam logic [15:0] EBCD1 = 16'h7119;
    localparam int          EPOKE = 7218;
    localparam logic [15:0] EBCD2 = 16'h7218;
`else
    localparam int          E120  = 7029;
    localparam logic [15:0] EBCD1 = 16'h7029;
    localparam int          EPOKE = 7128;
    localparam logic [15:0] EBCD2 = 16'h7128;
`endif

    score_engine dut (
        .clk(clk), .rst(rst), .hit(hit), .miss(miss), .clear(clear),
        .score(score), .combo(combo), .high_score(high_score),
        .bcd_req(bcd_req), .bcd_sel(bcd_sel), .bcd_busy(bcd_busy),
        .bcd_valid(bcd_valid), .bcd_out(bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input logic [1:0] h, input logic [1:0] m, input logic c);
        hit = h; miss = m; clear = c;
        @(posedge clk); #1;
        hit = 2'b00; miss = 2'b00; clear = 1'b0;
    endtask

    // poke: 1 = hit player 0 mid-conversion, 2 = clear mid-conversion.
    task automatic convert(input logic [1:0] sel, input logic [15:0] exp, input int poke);
        int cyc;
        bcd_sel = sel; bcd_req = 1'b1;
        @(posedge clk); #1;
        bcd_req = 1'b0;
        cyc = 1;
        check("busy_start", 32'(bcd_busy), 1);
        while (!bcd_valid && cyc < 40) begin
            if (cyc == 3 && poke == 1) hit = 2'b01;
            if (cyc == 3 && poke == 2) clear = 1'b1;
            if (cyc == 5) begin bcd_req = 1'b1; bcd_sel = 2'd1; end
            @(posedge clk); #1;
            hit = 2'b00; clear = 1'b0; bcd_req = 1'b0;
            cyc++;
        end
        check("valid_latency", 32'(cyc), 15);
        check("bcd_out", 32'(bcd_out), 32'(exp));
        check("busy_at_valid", 32'(bcd_busy), 1);
        @(posedge clk); #1;
        check("valid_one_cycle", 32'(bcd_valid), 0);
        check("busy_end", 32'(bcd_busy), 0);
    endtask

    initial begin
        int vcount;
        rst = 1'b1; hit = '0; miss = '0; clear = 1'b0; bcd_req = 1'b0; bcd_sel = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_score0", 32'(score[13:0]), 0);
        check("rst_score1", 32'(score[27:14]), 0);
        check("rst_combo0", 32'(combo[6:0]), 0);
        check("rst_high", 32'(high_score), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_busy", 32'(bcd_busy), 0);
        check("rst_valid", 32'(bcd_valid), 0);

        tick(2'b01, 2'b00, 1'b0);
        check("h1_combo", 32'(combo[6:0]), 1);  check("h1_score", 32'(score[13:0]), 1);
        tick(2'b01, 2'b00, 1'b0);
        check("h2_combo", 32'(combo[6:0]), 2);  check("h2_score", 32'(score[13:0]), 3);
        tick(2'b01, 2'b00, 1'b0);
        check("h3_combo", 32'(combo[6:0]), 3);  check("h3_score", 32'(score[13:0]), 6);
        tick(2'b00, 2'b01, 1'b0);
        check("miss_combo", 32'(combo[6:0]), 0); check("miss_score", 32'(score[13:0]), 6);
        check("p1_idle", 32'(score[27:14]), 0);

        repeat (5) tick(2'b10, 2'b00, 1'b0);
        check("p1_combo5", 32'(combo[13:7]), 5); check("p1_score15", 32'(score[27:14]), 15);
        tick(2'b10, 2'b10, 1'b0);
        check("hm_combo", 32'(combo[13:7]), 0); check("hm_score", 32'(score[27:14]), 15);
        check("hm_p0_score", 32'(score[13:0]), 6);
        check("high15", 32'(high_score), 15);

        tick(2'b00, 2'b00, 1'b1);
        check("clr_score0", 32'(score[13:0]), 0);
        check("clr_score1", 32'(score[27:14]), 0);
        check("clr_combo1", 32'(combo[13:7]), 0);
        check("clr_high", 32'(high_score), 15);

        repeat (120) tick(2'b01, 2'b00, 1'b0);
        check("c120_combo", 32'(combo[6:0]), 99);
        check("c120_score", 32'(score[13:0]), 32'(E120));
        check("c120_high", 32'(high_score), 32'(E120));

        convert(2'd0, EBCD1, 1);
        check("poke_score", 32'(score[13:0]), 32'(EPOKE));
        convert(2'd2, EBCD2, 2);
        check("conv_clear_score", 32'(score[13:0]), 0);
        check("conv_clear_high", 32'(high_score), 32'(EPOKE));

        repeat (150) tick(2'b01, 2'b00, 1'b0);
        check("sat_score", 32'(score[13:0]), 9999);
        check("sat_high", 32'(high_score), 9999);
        tick(2'b00, 2'b00, 1'b1);
        check("sat_clr_score", 32'(score[13:0]), 0);
        check("sat_clr_combo", 32'(combo[6:0]), 0);
        check("sat_clr_high", 32'(high_score), 9999);

        tick(2'b01, 2'b00, 1'b0);
        bcd_sel = 2'd0; bcd_req = 1'b1;
        @(posedge clk); #1;
        bcd_req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bcd_busy), 0);
        check("abort_valid", 32'(bcd_valid), 0);
        check("abort_bcd", 32'(bcd_out), 0);
        check("abort_score0", 32'(score[13:0]), 0);
        check("abort_high", 32'(high_score), 0);
        vcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bcd_valid) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
